rx_frame_ctrl: RTL and testbench

- Receive-side frame controller placed after the decoder in the receiver chain.
- Consumes the decoded serial bit stream (bit plus strobe) and hunts for a fixed sync word.
- Once locked, counts a fixed-length payload, assembles it MSB-first into bytes and hands each byte out over a single-entry valid/ready holding register.
- Aborts and resynchronises on bit-gap timeout or output overrun.

---
 rtl/rx_pkg.sv | 24 ++
 rtl/rx_sync_detect.sv | 30 +++
 rtl/rx_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the receive frame controller: state encoding,
// default sync word and byte container.
package rx_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HUNT    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  localparam int unsigned            SYNC_WIDTH_DEF = 16;
  localparam logic [SYNC_WIDTH_DEF-1:0] SYNC_WORD_DEF = 16'hEB90;

  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              err;
  } rx_byte_t;

  // Even parity: a mismatch means the data ones plus the parity bit are odd.
  function automatic logic par_err(input logic [BYTE_W-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

endpackage

// File: rtl/rx_sync_detect.sv
// Sync-word hunter: LSB-in shift register with a compare on the post-shift
// value, so match_o fires in the same cycle as the completing strobe.
module rx_sync_detect
  import rx_pkg::*;
#(
  parameter int unsigned             SYNC_WIDTH = SYNC_WIDTH_DEF,
  parameter logic [SYNC_WIDTH-1:0]   SYNC_WORD  = SYNC_WORD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_i,
  output logic match_o
);

  // Only the newest SYNC_WIDTH-1 bits need storing; the incoming bit
  // completes the window for the compare.
  logic [SYNC_WIDTH-2:0] hist_q;
  logic [SYNC_WIDTH-1:0] window;

  assign window  = {hist_q, bit_i};
  assign match_o = shift_en && !clear && (window == SYNC_WORD);

  always_ff @(posedge clk) begin
    if (reset || clear) hist_q <= '0;
    else if (shift_en)  hist_q <= window[SYNC_WIDTH-2:0];
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: sync hunt, fixed-length payload byte assembly,
// single-entry output holding register. RX_FRAME_PARITY_EN adds a parity bit per byte.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int unsigned           SYNC_WIDTH     = SYNC_WIDTH_DEF,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD      = SYNC_WORD_DEF,
  parameter int unsigned           PAYLOAD_BYTES  = 4,
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        bit_i,
  input  logic        bit_valid_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        byte_err_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
);

`ifdef RX_FRAME_PARITY_EN
  localparam int unsigned BITS_PER_BYTE = BYTE_W + 1;
  localparam int unsigned SR_W          = BYTE_W;
`else
  localparam int unsigned BITS_PER_BYTE = BYTE_W;
  localparam int unsigned SR_W          = BYTE_W - 1;
`endif

  localparam int unsigned BITW = $clog2(BITS_PER_BYTE) + 1;
  localparam int unsigned BCW  = $clog2(PAYLOAD_BYTES) + 1;
  localparam int unsigned GW   = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [BITW-1:0] LAST_BIT  = BITW'(BITS_PER_BYTE - 1);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(PAYLOAD_BYTES - 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_q;
  logic [BITW-1:0] bit_cnt;
  logic [BCW-1:0]  byte_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [SR_W-1:0] data_sr;
  rx_byte_t        hold_q;
  rx_byte_t        asm_byte;
  logic            hold_vld;
  logic            data_bit;
  logic            sync_match;
  logic            drain;

  // Sync history is held clear outside HUNT, so payload bits never match
  // and every hunt starts from a clean window.
  rx_sync_detect #(
    .SYNC_WIDTH (SYNC_WIDTH),
    .SYNC_WORD  (SYNC_WORD)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q != ST_HUNT),
    .shift_en (enable_i && bit_valid_i && (state_q == ST_HUNT)),
    .bit_i    (bit_i),
    .match_o  (sync_match)
  );

  assign drain = hold_vld && byte_ready_i;

  always_comb begin
    asm_byte = '0;
    data_bit = 1'b1;
`ifdef RX_FRAME_PARITY_EN
    data_bit      = (bit_cnt < BITW'(BYTE_W));
    asm_byte.data = data_sr;
    asm_byte.err  = par_err(data_sr, bit_i);
`else
    asm_byte.data = {data_sr, bit_i};
    asm_byte.err  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      gap_cnt       <= '0;
      data_sr       <= '0;
      hold_q        <= '0;
      hold_vld      <= 1'b0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
      if (drain) hold_vld <= 1'b0;

      if (!enable_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_HUNT;
          ST_HUNT: begin
            if (sync_match) begin
              state_q       <= ST_PAYLOAD;
              frame_start_o <= 1'b1;
              bit_cnt       <= '0;
              byte_cnt      <= '0;
              gap_cnt       <= '0;
            end
          end
          ST_PAYLOAD: begin
            if (bit_valid_i) begin
              gap_cnt <= '0;
              if (data_bit) data_sr <= {data_sr[SR_W-2:0], bit_i};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                // A same-cycle drain frees the slot for the new byte.
                if (!hold_vld || drain) begin
                  hold_q   <= asm_byte;
                  hold_vld <= 1'b1;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == LAST_BYTE) begin
                    frame_done_o <= 1'b1;
                    state_q      <= ST_HUNT;
                  end
                end else begin
                  overrun_o <= 1'b1;
                  state_q   <= ST_HUNT;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (gap_cnt == GAP_LAST) begin
              timeout_o <= 1'b1;
              state_q   <= ST_HUNT;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign byte_o       = hold_q.data;
  assign byte_err_o   = hold_q.err;
  assign byte_valid_o = hold_vld;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: sync hunt, delivery, overrun, timeout,
// enable/reset abort, and parity when RX_FRAME_PARITY_EN is defined.
module tb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable_i, bit_i, bit_valid_i, byte_ready_i;
  logic [7:0] byte_o;
  logic       byte_valid_o, byte_err_o, frame_start_o, frame_done_o;
  logic       overrun_o, timeout_o;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  int         n_start = 0, n_done = 0, n_ovr = 0, n_tmo = 0;
  logic [7:0] done_byte = 8'h00;
  logic [7:0] q_byte[$];
  logic       q_err[$];

  rx_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable_i),
    .bit_i         (bit_i),
    .bit_valid_i   (bit_valid_i),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .byte_ready_i  (byte_ready_i),
    .byte_err_o    (byte_err_o),
    .frame_start_o (frame_start_o),
    .frame_done_o  (frame_done_o),
    .overrun_o     (overrun_o),
    .timeout_o     (timeout_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // Observe pulses and accepted bytes between clock edges.
  always @(negedge clk) begin
    if (frame_start_o) n_start++;
    if (frame_done_o) begin n_done++; done_byte = byte_o; end
    if (overrun_o) n_ovr++;
    if (timeout_o) n_tmo++;
    if (byte_valid_o && byte_ready_i) begin
      q_byte.push_back(byte_o);
      q_err.push_back(byte_err_o);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_i = b; bit_valid_i = 1'b1;
    @(posedge clk); #1;
    bit_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_byte_par(input logic [7:0] b, input logic p);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
`ifdef RX_FRAME_PARITY_EN
    send_bit(p);
`else
    if (p) begin end
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_par(b, ^b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0; byte_ready_i = 1'b0;
    do_reset();
    n_cmp++;
    if ({byte_o, byte_valid_o, byte_err_o, frame_start_o, frame_done_o,
         overrun_o, timeout_o, state_o} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got byte=%h v=%b e=%b fs=%b fd=%b ov=%b to=%b st=%0d, want all 0",
               byte_o, byte_valid_o, byte_err_o, frame_start_o, frame_done_o,
               overrun_o, timeout_o, state_o);
    end
    enable_i = 1'b1;
    cycles(2);
    n_cmp++;
    if (state_o !== 2'd1) begin n_bad++; $display("FAIL idle_to_hunt: state %0d want 1", state_o); end
  endtask

  task automatic test_basic_frame();
    int s0, d0, o0, q0;
    logic [7:0] exp[4];
    exp[0] = 8'h12; exp[1] = 8'h34; exp[2] = 8'h56; exp[3] = 8'h78;
    s0 = n_start; d0 = n_done; o0 = n_ovr; q0 = q_byte.size();
    byte_ready_i = 1'b1;
    send_word(16'hEB90);
    for (int i = 0; i < 4; i++) send_byte(exp[i]);
    cycles(3);
    n_cmp++;
    if (n_start - s0 != 1) begin n_bad++; $display("FAIL basic_start_cnt: %0d want 1", n_start - s0); end
    n_cmp++;
    if (q_byte.size() - q0 != 4) begin n_bad++; $display("FAIL basic_byte_cnt: %0d want 4", q_byte.size() - q0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (q_byte[q0+i] !== exp[i] || q_err[q0+i] !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_byte%0d: %h err=%b want %h err=0", i, q_byte[q0+i], q_err[q0+i], exp[i]);
        end
      end
    end
    n_cmp++;
    if (n_done - d0 != 1 || done_byte !== 8'h78) begin
      n_bad++; $display("FAIL basic_done: cnt %0d byte %h want 1 / 78", n_done - d0, done_byte);
    end
    n_cmp++;
    if (state_o !== 2'd1 || n_ovr != o0) begin
      n_bad++; $display("FAIL basic_end_state: state %0d ovr %0d want 1 / 0", state_o, n_ovr - o0);
    end
  endtask

  task automatic test_bad_sync();
    int s0, q0;
    s0 = n_start; q0 = q_byte.size();
    send_word(16'hEB91);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    cycles(3);
    n_cmp++;
    if (n_start != s0 || state_o !== 2'd1 || q_byte.size() != q0) begin
      n_bad++;
      $display("FAIL bad_sync: starts %0d state %0d bytes %0d want 0 / 1 / 0",
               n_start - s0, state_o, q_byte.size() - q0);
    end
  endtask

  task automatic test_overrun();
    int o0, d0, q0;
    o0 = n_ovr; d0 = n_done; q0 = q_byte.size();
    byte_ready_i = 1'b0;
    send_word(16'hEB90);
    send_byte(8'h12);
    cycles(1);
    n_cmp++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h12) begin
      n_bad++; $display("FAIL ovr_held: v=%b byte=%h want 1 / 12", byte_valid_o, byte_o);
    end
    send_byte(8'h34);
    cycles(2);
    n_cmp++;
    if (n_ovr - o0 != 1 || state_o !== 2'd1) begin
      n_bad++; $display("FAIL ovr_pulse: ovr %0d state %0d want 1 / 1", n_ovr - o0, state_o);
    end
    n_cmp++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h12 || n_done != d0) begin
      n_bad++; $display("FAIL ovr_kept: v=%b byte=%h done=%0d want 1 / 12 / 0", byte_valid_o, byte_o, n_done - d0);
    end
    byte_ready_i = 1'b1;
    cycles(3);
    n_cmp++;
    if (q_byte.size() - q0 != 1 || byte_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL ovr_drain_cnt: %0d bytes v=%b want 1 / 0", q_byte.size() - q0, byte_valid_o);
    end else if (q_byte[q0] !== 8'h12) begin
      n_bad++; $display("FAIL ovr_drain_byte: %h want 12", q_byte[q0]);
    end
  endtask

  task automatic test_timeout();
    int t0, q0, n;
    t0 = n_tmo; q0 = q_byte.size();
    send_word(16'hEB90);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n = 0;
    while (n < 1100 && !timeout_o) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!timeout_o || n < 1023 || n > 1027) begin
      n_bad++; $display("FAIL timeout_gap: seen=%b after %0d cycles want 1 near 1025", timeout_o, n);
    end
    cycles(2);
    n_cmp++;
    if (n_tmo - t0 != 1 || state_o !== 2'd1 || q_byte.size() != q0 || byte_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_after: pulses %0d state %0d bytes %0d v=%b want 1 / 1 / 0 / 0",
               n_tmo - t0, state_o, q_byte.size() - q0, byte_valid_o);
    end
  endtask

  task automatic test_enable_abort();
    int q0;
    q0 = q_byte.size();
    byte_ready_i = 1'b1;
    send_word(16'hEB90);
    send_byte(8'h12);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    @(posedge clk); #1;
    bit_i = 1'b1; bit_valid_i = 1'b0 | 1'b1; enable_i = 1'b0;
    @(posedge clk); #1;
    bit_valid_i = 1'b0;
    n_cmp++;
    if (state_o !== 2'd0) begin n_bad++; $display("FAIL en_abort_state: %0d want 0", state_o); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    enable_i = 1'b1;
    cycles(3);
    n_cmp++;
    if (q_byte.size() - q0 != 1 || state_o !== 2'd1) begin
      n_bad++; $display("FAIL en_abort_bytes: %0d bytes state %0d want 1 / 1", q_byte.size() - q0, state_o);
    end else if (q_byte[q0] !== 8'h12) begin
      n_bad++; $display("FAIL en_abort_first: %h want 12", q_byte[q0]);
    end
  endtask

  task automatic test_reset_midframe();
    byte_ready_i = 1'b0;
    send_word(16'hEB90);
    send_byte(8'h34);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    n_cmp++;
    if (byte_valid_o !== 1'b1 || state_o !== 2'd2) begin
      n_bad++; $display("FAIL pre_reset: v=%b state %0d want 1 / 2", byte_valid_o, state_o);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({byte_o, byte_valid_o, byte_err_o, frame_start_o, frame_done_o,
         overrun_o, timeout_o, state_o} !== 15'd0) begin
      n_bad++;
      $display("FAIL midframe_reset: byte=%h v=%b st=%0d want all 0", byte_o, byte_valid_o, state_o);
    end
    reset = 1'b0;
    cycles(2);
  endtask

`ifdef RX_FRAME_PARITY_EN
  task automatic test_parity();
    byte_ready_i = 1'b0;
    send_word(16'hEB90);
    send_byte_par(8'h12, 1'b1);
    cycles(1);
    n_cmp++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h12 || byte_err_o !== 1'b1) begin
      n_bad++; $display("FAIL par_bad: v=%b byte=%h err=%b want 1 / 12 / 1", byte_valid_o, byte_o, byte_err_o);
    end
    byte_ready_i = 1'b1;
    cycles(1);
    byte_ready_i = 1'b0;
    send_byte_par(8'h34, 1'b1);
    cycles(1);
    n_cmp++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h34 || byte_err_o !== 1'b0) begin
      n_bad++; $display("FAIL par_good: v=%b byte=%h err=%b want 1 / 34 / 0", byte_valid_o, byte_o, byte_err_o);
    end
    byte_ready_i = 1'b1;
    cycles(2);
  endtask
`endif

  initial begin
    reset = 1'b0;
    test_reset();
    test_basic_frame();
    test_bad_sync();
    test_overrun();
    test_timeout();
    test_enable_abort();
    test_reset_midframe();
`ifdef RX_FRAME_PARITY_EN
    enable_i = 1'b1;
    cycles(2);
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
